mix_columns_serial: RTL and testbench
=====================================

# mix_columns_serial

Column-serial AES MixColumns stage for the 128-bit datapath. It accepts one 128-bit state after ShiftRows over a valid/ready handshake, transforms one 32-bit column per clock using GF(2^8) doubling (xtime) units, and presents the result to AddRoundKey over a second valid/ready handshake. Area is traded for latency: one column datapath is shared across four cycles.

## Interface
- `NUM_COLS`, 4: columns per state; fixed for AES-128, used for counter sizing only.
- Reset: one clock; reset is asynchronous and active-low.
- `clk` input 1: rising-edge clock.
- `n_rst` input 1: asynchronous active-low reset.
- `in_valid` input 1: `data_in` holds a state to transform.
- `in_ready` output 1: block can accept a state; high only in IDLE.
- `data_in` input 128: input state. Column c = bits [127-32c -: 32]. Row 0 byte is the MSB of each column.
- `out_valid` output 1: `data_out` holds a completed result.
- `out_ready` input 1: downstream accepts `data_out`.
- `data_out` output 128: transformed state, same byte ordering as `data_in`.
- `inv_mode` input 1: present only with `MIX_COLUMNS_INV_EN`; selects InvMixColumns.

## Operation
- Forward transform per column (s0..s3 → r0..r3):
  - r0 = 2s0^3s1^s2^s3
  - r1 = s0^2s1^3s2^s3
  - r2 = s0^s1^2s2^3s3
  - r3 = 3s0^s1^s2^2s3
- Multiplication rules: 2x = xtime(x), reduced by polynomial 0x11B; 3x = 2x^x. All arithmetic is 8-bit XOR; there is no carry.
- FSM:
  - IDLE: `in_ready`=1. On `in_valid`, latch `data_in` (and `inv_mode`), set col=0, go to BUSY.
  - BUSY: each cycle, write the transformed column col into the result register, then col++. When col=3 is written, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- The input register is captured only at acceptance. Later changes to `data_in` have no effect.
- While `out_valid`=1 and `out_ready`=0, `data_out` and `out_valid` hold stable.
- `in_valid` is ignored outside IDLE. There is no bypass accept in DONE.
- Asserting `out_ready` while not in DONE has no effect.
- The column counter wraps 3→0 only through IDLE. It never indexes beyond 3.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `data_out`=0
  - col=0
  - internal registers = 0
- Reset takes effect immediately (asynchronous). Assertion mid-BUSY or mid-DONE abandons the block; no output is produced.
- Latency: acceptance at edge T; columns are written at edges T+1..T+4; `out_valid`=1 in the cycle after T+4.
- Throughput: at most one state per 6 cycles with `out_ready` tied high (accept, 4 compute, 1 handoff).
- `in_ready` and `out_valid` are decoded from registered state. There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `MIX_COLUMNS_INV_EN` defined:
  - Adds the `inv_mode` port, sampled at acceptance.
  - `inv_mode`=1 applies the InvMixColumns coefficients 0e/0b/0d/09. They are built from chained doublings (2x, 4x, 8x) and XOR.
  - Latency is unchanged.
- `MIX_COLUMNS_INV_EN` undefined:
  - `inv_mode` is absent.
  - Forward only; no inverse logic is synthesized.

## Structure
- Shared package `aes_pkg` holds:
  - `byte_t` (8b), `word_t` (32b), `state_t` (128b)
  - `NUM_COLS`
  - the FSM enum `mc_state_e` {IDLE, BUSY, DONE}
- One combinational sub-module, `mix_single_column`:
  - word_t in → word_t out (plus the inverse select when compiled in).
  - Instantiates the existing GF doubling module per byte.
- The top level holds the FSM, counter, input and result registers, and column muxing.

## Test plan
- Forward vector:
  - Stimulus: `data_in`=db135345_f20a225c_01010101_c6c6c6c6, `out_ready`=1.
  - Response: `data_out`=8e4da1bc_9fdc589d_01010101_c6c6c6c6, `out_valid` rising 4 cycles after the accept edge, high for 1 cycle.
- FIPS-197 round-1 vector:
  - Stimulus: columns d4bf5d30_e0b452ae_b84111f1_1e2798e5.
  - Response: 046681e5_e0cb199a_48f8d37a_2806264c.
- Backpressure:
  - Stimulus: `out_ready`=0 for 10 cycles after `out_valid`, with `in_valid` pulsed meanwhile.
  - Response: `data_out` stable, `in_ready`=0, second input not taken. `out_ready`=1 → IDLE next cycle.
- Reset mid-operation:
  - Stimulus: `n_rst` low during BUSY col=2.
  - Response: `out_valid`=0, `data_out`=0, `in_ready`=1 immediately. No stray `out_valid` after release.
- Back-to-back:
  - Stimulus: `in_valid` held high with two states, `out_ready`=1.
  - Response: second accepted on the first cycle `in_ready` returns (6-cycle spacing). Both outputs correct.
- Inverse (macro defined):
  - Stimulus: `inv_mode`=1, `data_in`=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - Response: db135345_f20a225c_01010101_c6c6c6c6.

Source files
------------

// File: rtl/mix_columns_serial_pkg.sv
// Shared AES types, sizing constants and the MixColumns FSM encoding.
// Used by the column-serial MixColumns stage, its interface and bench.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  // Columns per AES-128 state; only sizes the column counter.
  localparam int NUM_COLS = 4;
  localparam int COL_W    = $clog2(NUM_COLS);

  typedef logic [COL_W-1:0] col_t;

  localparam col_t LAST_COL = col_t'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

endpackage : aes_pkg

// File: rtl/mix_columns_serial_if.sv
// Handshake bundle between ShiftRows (master side), the MixColumns stage
// (slave side) and AddRoundKey. The inv_mode signal exists only when
// MIX_COLUMNS_INV_EN is defined.
interface mix_columns_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t data_in;
  logic   out_valid;
  logic   out_ready;
  state_t data_out;
`ifdef MIX_COLUMNS_INV_EN
  logic   inv_mode;
`endif

  // Upstream/downstream environment driving the stage.
  modport master (
    output in_valid,
    output data_in,
    output out_ready,
`ifdef MIX_COLUMNS_INV_EN
    output inv_mode,
`endif
    input  in_ready,
    input  out_valid,
    input  data_out
  );

  // The MixColumns stage itself.
  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
`ifdef MIX_COLUMNS_INV_EN
    input  inv_mode,
`endif
    output in_ready,
    output out_valid,
    output data_out
  );

endinterface : mix_columns_if

// File: rtl/mix_columns_serial_col.sv
// Combinational single-column MixColumns: GF(2^8) doubling unit plus the
// 4-byte column mixer built from it. With MIX_COLUMNS_INV_EN defined the
// mixer also offers InvMixColumns (0e/0b/0d/09) from chained doublings.

// GF(2^8) doubling (xtime), reduction polynomial 0x11B.
module gf_xtime
  import aes_pkg::*;
(
  input  byte_t a,
  output byte_t y
);
  assign y = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
endmodule : gf_xtime

// Mixes one 32-bit column; byte 0 (row 0) is the column MSB.
module mix_single_column
  import aes_pkg::*;
(
  input  word_t col_in,
`ifdef MIX_COLUMNS_INV_EN
  input  logic  inv,
`endif
  output word_t col_out
);

  byte_t s   [4];
  byte_t x2  [4];
  byte_t fwd [4];
`ifdef MIX_COLUMNS_INV_EN
  byte_t x4  [4];
  byte_t x8  [4];
  byte_t m9  [4];
  byte_t mb  [4];
  byte_t md  [4];
  byte_t me  [4];
  byte_t inv_r [4];
`endif

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign s[i] = col_in[31-8*i -: 8];

    gf_xtime u_x2 (.a(s[i]), .y(x2[i]));

    // Circulant row i of {2,3,1,1}: 2*s[i] ^ 3*s[i+1] ^ s[i+2] ^ s[i+3].
    assign fwd[i] = x2[i] ^ x2[(i+1)%4] ^ s[(i+1)%4] ^ s[(i+2)%4] ^ s[(i+3)%4];

`ifdef MIX_COLUMNS_INV_EN
    gf_xtime u_x4 (.a(x2[i]), .y(x4[i]));
    gf_xtime u_x8 (.a(x4[i]), .y(x8[i]));

    assign m9[i] = x8[i] ^ s[i];
    assign mb[i] = x8[i] ^ x2[i] ^ s[i];
    assign md[i] = x8[i] ^ x4[i] ^ s[i];
    assign me[i] = x8[i] ^ x4[i] ^ x2[i];
`endif
  end

`ifdef MIX_COLUMNS_INV_EN
  // Circulant row i of {0e,0b,0d,09}.
  for (genvar i = 0; i < 4; i++) begin : g_inv_row
    assign inv_r[i] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
  end
`endif

  // Pack the four result bytes back into a column, row 0 in the MSB.
  always_comb begin
    col_out = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef MIX_COLUMNS_INV_EN
      col_out[31-8*i -: 8] = inv ? inv_r[i] : fwd[i];
`else
      col_out[31-8*i -: 8] = fwd[i];
`endif
    end
  end

endmodule : mix_single_column

// File: rtl/mix_columns_serial.sv
// Column-serial AES MixColumns stage. Accepts one 128-bit state, mixes one
// column per clock through a shared column datapath (4 cycles), then holds
// the result until downstream takes it.
// Optional feature macro: MIX_COLUMNS_INV_EN adds inv_mode / InvMixColumns.
module mix_columns_serial
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  mix_columns_if.slave bus
);

  mc_state_e state;
  mc_state_e state_next;
  col_t      col;
  state_t    in_reg;
  state_t    res_reg;
  word_t     col_in;
  word_t     col_out;
  logic      accept;
`ifdef MIX_COLUMNS_INV_EN
  logic      inv_reg;
`endif

  // A state is taken only in IDLE; in_valid is ignored everywhere else.
  assign accept = (state == IDLE) && bus.in_valid;

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch
    // is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid)      state_next = BUSY;
      BUSY:    if (col == LAST_COL)   state_next = DONE;
      DONE:    if (bus.out_ready)     state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // FSM outputs, decoded from the registered state only.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  assign bus.data_out = res_reg;

  // Column select from the captured input state.
  always_comb begin
    col_in = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (col == col_t'(i)) col_in = in_reg[127-32*i -: 32];
    end
  end

  mix_single_column u_col (
    .col_in  (col_in),
`ifdef MIX_COLUMNS_INV_EN
    .inv     (inv_reg),
`endif
    .col_out (col_out)
  );

  // Input capture at acceptance; column write-back and counter in BUSY.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: the state-wide registers are ordinary flops, not a memory, so
    // clearing them on reset is cheap and keeps data_out defined at 0.
    if (!n_rst) begin
      in_reg  <= '0;
      res_reg <= '0;
      col     <= '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_reg <= 1'b0;
`endif
    end else if (accept) begin
      in_reg  <= bus.data_in;
      col     <= '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_reg <= bus.inv_mode;
`endif
    end else if (state == BUSY) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        if (col == col_t'(i)) res_reg[127-32*i -: 32] <= col_out;
      end
      // The counter parks on the last column; only acceptance rewinds it.
      if (col != LAST_COL) col <= col + 1'b1;
    end
  end

endmodule : mix_columns_serial

// File: tb/tb_mix_columns_serial.sv
// Self-checking bench for mix_columns_serial: known-answer table, protocol
// corner sequences (backpressure, mid-operation reset, back-to-back) and
// random states against a GF(2^8) matrix reference model.
module tb_mix_columns_serial;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  mix_columns_if bus ();

  mix_columns_serial dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    state_t din;
    bit     inv;
    state_t exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Generic GF(2^8) multiply by shift-and-add, modulo 0x11B.
  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t p = 8'h00;
    byte_t x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Matrix product of each column with the (Inv)MixColumns circulant matrix.
  function automatic state_t mix_model(state_t s, bit inv);
    byte_t  coef[4];
    byte_t  acc;
    state_t r = '0;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gf_mul(s[127-32*c-8*j -: 8], coef[(j - i + 4) % 4]);
        r[127-32*c-8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Offer one state from IDLE, wait (bounded) for out_valid; lat counts
  // clock edges from the accept edge to the edge that raises out_valid.
  task automatic run_one(input state_t din, input bit inv, output state_t dout, output int lat);
    check_bit("ready_before_accept", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.data_in  = din;
`ifdef MIX_COLUMNS_INV_EN
    bus.inv_mode = inv;
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.data_in  = ~din;
`ifdef MIX_COLUMNS_INV_EN
    bus.inv_mode = ~inv;
`endif
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    dout = bus.data_out;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    state_t dout;
    state_t exp_a;
    state_t st_a;
    state_t st_b;
    int     lat;
    int     stray;
    int     acc_cyc[$];
    state_t outs[$];
    logic   acc_now;
    bit     inv;

    vecs.push_back('{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                     128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6});
    vecs.push_back('{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
                     128'h046681e5_e0cb199a_48f8d37a_2806264c});
`ifdef MIX_COLUMNS_INV_EN
    vecs.push_back('{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
                     128'hdb135345_f20a225c_01010101_c6c6c6c6});
`endif

    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
    bus.inv_mode  = 1'b0;
`endif
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_in_ready", bus.in_ready, 1'b1);
    check_bit("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_data_out", bus.data_out, '0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Known-answer table with out_ready tied high.
    bus.out_ready = 1'b1;
    for (int v = 0; v < vecs.size(); v++) begin
      run_one(vecs[v].din, vecs[v].inv, dout, lat);
      check($sformatf("vec%0d_latency", v), 128'(lat), 128'(4));
      check($sformatf("vec%0d_data", v), dout, vecs[v].exp);
      @(posedge clk); #1;
      check_bit($sformatf("vec%0d_valid_one_cycle", v), bus.out_valid, 1'b0);
      check_bit($sformatf("vec%0d_back_idle", v), bus.in_ready, 1'b1);
    end

    // Backpressure: result holds, in_valid pulses are ignored.
    bus.out_ready = 1'b0;
    st_a  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    st_b  = 128'hffff_0000_1111_2222_3333_4444_5555_6666;
    exp_a = mix_model(st_a, 1'b0);
    run_one(st_a, 1'b0, dout, lat);
    check("bp_latency", 128'(lat), 128'(4));
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_hold_data_%0d", k), bus.data_out, exp_a);
      check_bit($sformatf("bp_hold_valid_%0d", k), bus.out_valid, 1'b1);
      check_bit($sformatf("bp_no_ready_%0d", k), bus.in_ready, 1'b0);
      bus.in_valid = (k % 2 == 0);
      bus.data_in  = st_b;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_bit("bp_release_idle", bus.in_ready, 1'b1);
    check_bit("bp_release_valid", bus.out_valid, 1'b0);
    stray = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid) stray++;
    end
    check("bp_second_not_taken", 128'(stray), 128'(0));
    check("bp_data_untouched", bus.data_out, exp_a);

    // Reset while BUSY with col = 2.
    bus.in_valid = 1'b1;
    bus.data_in  = st_b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_bit("mid_busy_before_reset", bus.in_ready, 1'b0);
    n_rst = 1'b0;
    #1;
    check_bit("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_data_out", bus.data_out, '0);
    check_bit("mid_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    n_rst = 1'b1;
    stray = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_valid) stray++;
    end
    check("mid_rst_no_stray_valid", 128'(stray), 128'(0));

    // Back-to-back: in_valid held high across two states.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.data_in   = st_a;
    for (int k = 0; k < 30; k++) begin
      acc_now = bus.in_valid && bus.in_ready;
      if (bus.out_valid) outs.push_back(bus.data_out);
      @(posedge clk); #1;
      if (acc_now) begin
        acc_cyc.push_back(k);
        if (acc_cyc.size() == 1) bus.data_in = st_b;
        else                     bus.in_valid = 1'b0;
      end
    end
    check("b2b_accept_count", 128'(acc_cyc.size()), 128'(2));
    if (acc_cyc.size() >= 2)
      check("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(6));
    check("b2b_output_count", 128'(outs.size()), 128'(2));
    if (outs.size() >= 2) begin
      check("b2b_first_data", outs[0], mix_model(st_a, 1'b0));
      check("b2b_second_data", outs[1], mix_model(st_b, 1'b0));
    end

    // Random states against the matrix model.
    for (int r = 0; r < 16; r++) begin
      st_a = {$urandom, $urandom, $urandom, $urandom};
`ifdef MIX_COLUMNS_INV_EN
      inv = 1'($urandom_range(0, 1));
`else
      inv = 1'b0;
`endif
      run_one(st_a, inv, dout, lat);
      check($sformatf("rand%0d_latency", r), 128'(lat), 128'(4));
      check($sformatf("rand%0d_data", r), dout, mix_model(st_a, inv));
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mix_columns_serial
